// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiplier states
// and the operand-forwarding match helper.
package execute_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_SLL   = 4'h5,
        ALU_SRL   = 4'h6,
        ALU_SRA   = 4'h7,
        ALU_SLT   = 4'h8,
        ALU_SLTU  = 4'h9,
        ALU_LUI   = 4'hA,
        ALU_AUIPC = 4'hB,
        ALU_MUL   = 4'hC
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic en, input logic [4:0] rd, input logic [4:0] rs);
        return en && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/execute_stage_alu_unit.sv
// Combinational RV32I ALU; results wrap modulo 2^XLEN, unknown opcodes give 0.
// The MUL opcode is handled by the iterative unit in execute_stage, so it yields 0 here.
module alu_unit
    import execute_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_LUI:   result = imm;
            ALU_AUIPC: result = pc + imm;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, forwarding muxes, ALU and EX/MEM register.
// Optional iterative multiplier enabled by defining EXECUTE_MUL_EN.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN = 32
`ifdef EXECUTE_MUL_EN
    , parameter int MUL_CYC = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            id_stall,
    input  logic            WriteBack,
    input  logic            MemoryRead,
    input  logic            MemoryWrite,
    input  logic [3:0]      aluOP,
    input  logic [2:0]      aluOP_2,
    input  logic            AluSrc,
    input  logic [XLEN-1:0] PC,
    input  logic [4:0]      IFID_rs1,
    input  logic [4:0]      IFID_rs2,
    input  logic [4:0]      IFID_rd,
    input  logic [XLEN-1:0] IFID_imm,
    input  logic [XLEN-1:0] IFID_read_data1,
    input  logic [XLEN-1:0] IFID_read_data2,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_regwrite,
    input  logic [XLEN-1:0] MEMEX_WriteBack,
    output logic            IDEX_MemoryRead,
    output logic [4:0]      IDEX_rd,
    output logic [XLEN-1:0] EXMEM_alu_result,
    output logic [XLEN-1:0] EXMEM_store_data,
    output logic [4:0]      EXMEM_rd,
    output logic            EXMEM_WriteBack,
    output logic            EXMEM_MemoryRead,
    output logic            EXMEM_MemoryWrite,
    output logic [2:0]      EXMEM_funct3,
    output logic            ex_busy
);

    logic            idex_wb;
    logic            idex_mw;
    logic [3:0]      idex_aluop;
    logic [2:0]      idex_funct3;
    logic            idex_alusrc;
    logic [XLEN-1:0] idex_pc;
    logic [4:0]      idex_rs1;
    logic [4:0]      idex_rs2;
    logic [XLEN-1:0] idex_imm;
    logic [XLEN-1:0] idex_rd1;
    logic [XLEN-1:0] idex_rd2;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] ex_result;
    logic            idex_hold;
    logic            exmem_bubble;
    logic            exmem_fwd_en;

    // A load in EX/MEM has no data yet; its value arrives later on the MEM/WB bus.
    assign exmem_fwd_en = EXMEM_WriteBack & ~EXMEM_MemoryRead;

    assign fwd_a = fwd_hit(exmem_fwd_en, EXMEM_rd, idex_rs1)   ? EXMEM_alu_result :
                   fwd_hit(memwb_regwrite, memwb_rd, idex_rs1) ? MEMEX_WriteBack  : idex_rd1;
    assign fwd_b = fwd_hit(exmem_fwd_en, EXMEM_rd, idex_rs2)   ? EXMEM_alu_result :
                   fwd_hit(memwb_regwrite, memwb_rd, idex_rs2) ? MEMEX_WriteBack  : idex_rd2;
    assign op_b  = idex_alusrc ? idex_imm : fwd_b;

    alu_unit #(.XLEN(XLEN)) u_alu (
        .op     (idex_aluop),
        .a      (fwd_a),
        .b      (op_b),
        .imm    (idex_imm),
        .pc     (idex_pc),
        .result (alu_result)
    );

`ifdef EXECUTE_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYC + 1);

    mul_state_e      mul_state;
    logic            busy_q;
    logic            mul_start;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic [XLEN-1:0] mul_acc;
    logic [CNT_W-1:0] mul_cnt;

    // The MUL must stay in ID/EX on its start edge too, so its rd/controls survive to DONE.
    assign mul_start    = (mul_state == MUL_IDLE) && (idex_aluop == ALU_MUL);
    assign idex_hold    = busy_q | mul_start;
    assign exmem_bubble = mul_start | (mul_state == MUL_RUN);
    assign ex_result    = (mul_state == MUL_DONE) ? mul_acc : alu_result;
    assign ex_busy      = busy_q;
`else
    assign idex_hold    = 1'b0;
    assign exmem_bubble = 1'b0;
    assign ex_result    = alu_result;
    assign ex_busy      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            IDEX_MemoryRead   <= 1'b0;
            IDEX_rd           <= '0;
            idex_wb           <= 1'b0;
            idex_mw           <= 1'b0;
            idex_aluop        <= '0;
            idex_funct3       <= '0;
            idex_alusrc       <= 1'b0;
            idex_pc           <= '0;
            idex_rs1          <= '0;
            idex_rs2          <= '0;
            idex_imm          <= '0;
            idex_rd1          <= '0;
            idex_rd2          <= '0;
            EXMEM_alu_result  <= '0;
            EXMEM_store_data  <= '0;
            EXMEM_rd          <= '0;
            EXMEM_WriteBack   <= 1'b0;
            EXMEM_MemoryRead  <= 1'b0;
            EXMEM_MemoryWrite <= 1'b0;
            EXMEM_funct3      <= '0;
`ifdef EXECUTE_MUL_EN
            mul_state         <= MUL_IDLE;
            busy_q            <= 1'b0;
            mul_a             <= '0;
            mul_b             <= '0;
            mul_acc           <= '0;
            mul_cnt           <= '0;
`endif
        end else begin
            if (!idex_hold) begin
                if (id_stall || !id_valid) begin
                    IDEX_MemoryRead <= 1'b0;
                    IDEX_rd         <= '0;
                    idex_wb         <= 1'b0;
                    idex_mw         <= 1'b0;
                    idex_aluop      <= '0;
                    idex_funct3     <= '0;
                    idex_alusrc     <= 1'b0;
                    idex_pc         <= '0;
                    idex_rs1        <= '0;
                    idex_rs2        <= '0;
                    idex_imm        <= '0;
                    idex_rd1        <= '0;
                    idex_rd2        <= '0;
                end else begin
                    IDEX_MemoryRead <= MemoryRead;
                    IDEX_rd         <= IFID_rd;
                    idex_wb         <= WriteBack;
                    idex_mw         <= MemoryWrite;
                    idex_aluop      <= aluOP;
                    idex_funct3     <= aluOP_2;
                    idex_alusrc     <= AluSrc;
                    idex_pc         <= PC;
                    idex_rs1        <= IFID_rs1;
                    idex_rs2        <= IFID_rs2;
                    idex_imm        <= IFID_imm;
                    idex_rd1        <= IFID_read_data1;
                    idex_rd2        <= IFID_read_data2;
                end
            end

            if (exmem_bubble) begin
                EXMEM_alu_result  <= '0;
                EXMEM_store_data  <= '0;
                EXMEM_rd          <= '0;
                EXMEM_WriteBack   <= 1'b0;
                EXMEM_MemoryRead  <= 1'b0;
                EXMEM_MemoryWrite <= 1'b0;
                EXMEM_funct3      <= '0;
            end else begin
                EXMEM_alu_result  <= ex_result;
                EXMEM_store_data  <= fwd_b;
                EXMEM_rd          <= IDEX_rd;
                EXMEM_WriteBack   <= idex_wb;
                EXMEM_MemoryRead  <= IDEX_MemoryRead;
                EXMEM_MemoryWrite <= idex_mw;
                EXMEM_funct3      <= idex_funct3;
            end

`ifdef EXECUTE_MUL_EN
            // Shift-add, one multiplier bit per cycle; operands frozen at RUN entry.
            case (mul_state)
                MUL_IDLE: begin
                    if (mul_start) begin
                        mul_state <= MUL_RUN;
                        busy_q    <= 1'b1;
                        mul_a     <= fwd_a;
                        mul_b     <= op_b;
                        mul_acc   <= '0;
                        mul_cnt   <= CNT_W'(MUL_CYC - 1);
                    end
                end
                MUL_RUN: begin
                    if (mul_b[0]) begin
                        mul_acc <= mul_acc + mul_a;
                    end
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    if (mul_cnt == '0) begin
                        mul_state <= MUL_DONE;
                        busy_q    <= 1'b0;
                    end else begin
                        mul_cnt <= mul_cnt - CNT_W'(1);
                    end
                end
                MUL_DONE: mul_state <= MUL_IDLE;
                default:  mul_state <= MUL_IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed instructions push expected EX/MEM
// contents; a monitor pops and compares whenever EX/MEM carries a live instruction.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        id_stall;
    logic        WriteBack;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [3:0]  aluOP;
    logic [2:0]  aluOP_2;
    logic        AluSrc;
    logic [31:0] PC;
    logic [4:0]  IFID_rs1;
    logic [4:0]  IFID_rs2;
    logic [4:0]  IFID_rd;
    logic [31:0] IFID_imm;
    logic [31:0] IFID_read_data1;
    logic [31:0] IFID_read_data2;
    logic [4:0]  memwb_rd;
    logic        memwb_regwrite;
    logic [31:0] MEMEX_WriteBack;
    logic        IDEX_MemoryRead;
    logic [4:0]  IDEX_rd;
    logic [31:0] EXMEM_alu_result;
    logic [31:0] EXMEM_store_data;
    logic [4:0]  EXMEM_rd;
    logic        EXMEM_WriteBack;
    logic        EXMEM_MemoryRead;
    logic        EXMEM_MemoryWrite;
    logic [2:0]  EXMEM_funct3;
    logic        ex_busy;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] sd;
        bit          chk_sd;
        logic [4:0]  rd;
        logic [2:0]  ctl;
        logic [2:0]  f3;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt;

    execute_stage dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .id_stall          (id_stall),
        .WriteBack         (WriteBack),
        .MemoryRead        (MemoryRead),
        .MemoryWrite       (MemoryWrite),
        .aluOP             (aluOP),
        .aluOP_2           (aluOP_2),
        .AluSrc            (AluSrc),
        .PC                (PC),
        .IFID_rs1          (IFID_rs1),
        .IFID_rs2          (IFID_rs2),
        .IFID_rd           (IFID_rd),
        .IFID_imm          (IFID_imm),
        .IFID_read_data1   (IFID_read_data1),
        .IFID_read_data2   (IFID_read_data2),
        .memwb_rd          (memwb_rd),
        .memwb_regwrite    (memwb_regwrite),
        .MEMEX_WriteBack   (MEMEX_WriteBack),
        .IDEX_MemoryRead   (IDEX_MemoryRead),
        .IDEX_rd           (IDEX_rd),
        .EXMEM_alu_result  (EXMEM_alu_result),
        .EXMEM_store_data  (EXMEM_store_data),
        .EXMEM_rd          (EXMEM_rd),
        .EXMEM_WriteBack   (EXMEM_WriteBack),
        .EXMEM_MemoryRead  (EXMEM_MemoryRead),
        .EXMEM_MemoryWrite (EXMEM_MemoryWrite),
        .EXMEM_funct3      (EXMEM_funct3),
        .ex_busy           (ex_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stage stand-in: every load returns 0x99.
    always @(posedge clk) begin
        if (reset) begin
            memwb_rd        <= '0;
            memwb_regwrite  <= 1'b0;
            MEMEX_WriteBack <= '0;
        end else begin
            memwb_rd        <= EXMEM_rd;
            memwb_regwrite  <= EXMEM_WriteBack;
            MEMEX_WriteBack <= EXMEM_MemoryRead ? 32'h0000_0099 : EXMEM_alu_result;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (EXMEM_WriteBack || EXMEM_MemoryRead || EXMEM_MemoryWrite) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual_rd=%0d actual_result=%h required=none",
                         EXMEM_rd, EXMEM_alu_result);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_result"}, EXMEM_alu_result, mon_e.res);
                chk({mon_e.name, "_rd_ctl_f3"},
                    {21'b0, EXMEM_rd, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite, EXMEM_funct3},
                    {21'b0, mon_e.rd, mon_e.ctl, mon_e.f3});
                if (mon_e.chk_sd) chk({mon_e.name, "_store_data"}, EXMEM_store_data, mon_e.sd);
            end
        end
    end

    task automatic issue(input string name, input logic wb, input logic mr, input logic mw,
                         input logic [3:0] op, input logic [2:0] f3, input logic src,
                         input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] d1,
                         input logic [31:0] d2, input bit push, input logic [31:0] exp_res,
                         input bit chk_sd, input logic [31:0] exp_sd);
        exp_t e;
        @(negedge clk);
        id_valid = 1'b1;  id_stall = 1'b0;
        WriteBack = wb;   MemoryRead = mr;  MemoryWrite = mw;
        aluOP = op;       aluOP_2 = f3;     AluSrc = src;   PC = pc;
        IFID_rs1 = rs1;   IFID_rs2 = rs2;   IFID_rd = rd;   IFID_imm = imm;
        IFID_read_data1 = d1;  IFID_read_data2 = d2;
        if (push) begin
            e.name = name;  e.res = exp_res;  e.sd = exp_sd;  e.chk_sd = chk_sd;
            e.rd = rd;      e.ctl = {wb, mr, mw};  e.f3 = f3;
            exp_q.push_back(e);
        end
    endtask

    task automatic rr(input string n, input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] exp_res);
        issue(n, 1'b1, 1'b0, 1'b0, op, 3'd0, 1'b0, 32'h40, rs1, rs2, rd, 32'h0, d1, d2, 1'b1, exp_res, 1'b0, 32'h0);
    endtask

    task automatic ri(input string n, input logic [3:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] d1, input logic [31:0] imm, input logic [31:0] exp_res);
        issue(n, 1'b1, 1'b0, 1'b0, op, f3, 1'b1, 32'h40, 5'd1, 5'd2, rd, imm, d1, 32'h0, 1'b1, exp_res, 1'b0, 32'h0);
    endtask

    task automatic nop();
        @(negedge clk);
        id_valid = 1'b0;
        id_stall = 1'b0;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_exmem_result"}, EXMEM_alu_result, 32'h0);
        chk({p, "_exmem_store"}, EXMEM_store_data, 32'h0);
        chk({p, "_exmem_rd_ctl_f3"},
            {21'b0, EXMEM_rd, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite, EXMEM_funct3}, 32'h0);
        chk({p, "_idex"}, {26'b0, IDEX_MemoryRead, IDEX_rd}, 32'h0);
        chk({p, "_busy"}, {31'b0, ex_busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;  id_valid = 1'b0;  id_stall = 1'b0;
        WriteBack = 1'b0;  MemoryRead = 1'b0;  MemoryWrite = 1'b0;
        aluOP = '0;  aluOP_2 = '0;  AluSrc = 1'b0;  PC = '0;
        IFID_rs1 = '0;  IFID_rs2 = '0;  IFID_rd = '0;  IFID_imm = '0;
        IFID_read_data1 = '0;  IFID_read_data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // forwarding: EX/MEM, MEM/WB across a NOP, EX/MEM priority, operand B
        rr("add_x3", ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd12);
        rr("sub_fwd_exmem", ALU_SUB, 5'd4, 5'd3, 5'd1, 32'hBAD0, 32'd5, 32'd7);
        rr("add_x3_again", ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd12);
        nop();
        rr("sub_fwd_memwb", ALU_SUB, 5'd4, 5'd3, 5'd1, 32'hBAD0, 32'd5, 32'd7);
        rr("add_x3_base", ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd12);
        rr("add_x3_acc", ALU_ADD, 5'd3, 5'd3, 5'd1, 32'hBAD0, 32'd5, 32'd17);
        rr("sub_exmem_wins", ALU_SUB, 5'd4, 5'd3, 5'd1, 32'hBAD0, 32'd5, 32'd12);
        rr("add_fwd_b", ALU_ADD, 5'd5, 5'd1, 5'd4, 32'd5, 32'hBAD0, 32'd17);

        // x0 destination is never forwarded from either source
        ri("addi_x0", ALU_ADD, 3'd0, 5'd0, 32'd5, 32'd9, 32'd14);
        rr("x0_no_exmem", ALU_ADD, 5'd6, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        rr("x0_no_memwb", ALU_ADD, 5'd7, 5'd0, 5'd1, 32'd0, 32'd5, 32'd5);

        ri("sra", ALU_SRA, 3'd5, 5'd8, 32'h8000_0000, 32'd4, 32'hF800_0000);
        rr("sltu", ALU_SLTU, 5'd9, 5'd1, 5'd2, 32'd1, 32'hFFFF_FFFF, 32'd1);
        rr("slt_pos_neg", ALU_SLT, 5'd10, 5'd1, 5'd2, 32'd1, 32'hFFFF_FFFF, 32'd0);
        rr("slt_neg_pos", ALU_SLT, 5'd10, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 32'd1);
        rr("xor", ALU_XOR, 5'd11, 5'd1, 5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        rr("and", ALU_AND, 5'd11, 5'd1, 5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        rr("or", ALU_OR, 5'd11, 5'd1, 5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        rr("sll", ALU_SLL, 5'd11, 5'd1, 5'd2, 32'd1, 32'd31, 32'h8000_0000);
        ri("srl", ALU_SRL, 3'd5, 5'd11, 32'h8000_0000, 32'd4, 32'h0800_0000);
        ri("lui", ALU_LUI, 3'd0, 5'd11, 32'hBAD0, 32'h1234_5000, 32'h1234_5000);
        issue("auipc", 1'b1, 1'b0, 1'b0, ALU_AUIPC, 3'd0, 1'b1, 32'h100, 5'd1, 5'd2, 5'd11,
              32'h2000, 32'hBAD0, 32'h0, 1'b1, 32'h2100, 1'b0, 32'h0);
        rr("sub_wrap", ALU_SUB, 5'd11, 5'd1, 5'd2, 32'd0, 32'd1, 32'hFFFF_FFFF);
        rr("undef_op_d", 4'hD, 5'd11, 5'd1, 5'd2, 32'd3, 32'd5, 32'd0);

        // store: address from imm, data forwarded on B
        rr("add_x12", ALU_ADD, 5'd12, 5'd1, 5'd2, 32'd5, 32'd7, 32'd12);
        issue("sw_fwd", 1'b0, 1'b0, 1'b1, ALU_ADD, 3'd2, 1'b1, 32'h40, 5'd1, 5'd12, 5'd0,
              32'd8, 32'h100, 32'hBAD0, 1'b1, 32'h108, 1'b1, 32'd12);

        // load-use stall: bubble enters ID/EX, then EX/MEM; consumer forwards from MEM/WB
        issue("lw_x5", 1'b1, 1'b1, 1'b0, ALU_ADD, 3'd2, 1'b1, 32'h40, 5'd1, 5'd2, 5'd5,
              32'd4, 32'h200, 32'h0, 1'b1, 32'h204, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("stall_idex_memread", {31'b0, IDEX_MemoryRead}, 32'd1);
        chk("stall_idex_rd", {27'b0, IDEX_rd}, 32'd5);
        issue("stalled_add", 1'b1, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 32'h40, 5'd5, 5'd1, 5'd6,
              32'h0, 32'hBAD0, 32'd5, 1'b0, 32'h0, 1'b0, 32'h0);
        id_stall = 1'b1;
        @(posedge clk); #1;
        chk("bubble_idex", {26'b0, IDEX_MemoryRead, IDEX_rd}, 32'h0);
        rr("load_use_add", ALU_ADD, 5'd6, 5'd5, 5'd1, 32'hBAD0, 32'd5, 32'h9E);
        @(posedge clk); #1;
        chk("bubble_exmem", {24'b0, EXMEM_rd, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite}, 32'h0);

        // a load sitting in EX/MEM must not be forwarded
        issue("lw_x5_b", 1'b1, 1'b1, 1'b0, ALU_ADD, 3'd2, 1'b1, 32'h40, 5'd1, 5'd2, 5'd5,
              32'd4, 32'h200, 32'h0, 1'b1, 32'h204, 1'b0, 32'h0);
        rr("ld_no_exmem_fwd", ALU_ADD, 5'd7, 5'd5, 5'd1, 32'h100, 32'd5, 32'h105);

        // reset mid-stream clears a live ID/EX load and a live EX/MEM result
        rr("pre_reset_add", ALU_ADD, 5'd8, 5'd1, 5'd2, 32'd5, 32'd7, 32'd12);
        issue("lost_lw", 1'b1, 1'b1, 1'b0, ALU_ADD, 3'd2, 1'b1, 32'h40, 5'd1, 5'd2, 5'd9,
              32'd4, 32'h200, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("pre_reset_idex", {26'b0, IDEX_MemoryRead, IDEX_rd}, {26'b0, 1'b1, 5'd9});
        @(negedge clk);
        reset = 1'b1;
        id_valid = 1'b0;
        @(posedge clk); #1;
        chk_zero("midreset");
        @(negedge clk);
        reset = 1'b0;

`ifdef EXECUTE_MUL_EN
        rr("mul", ALU_MUL, 5'd13, 5'd1, 5'd2, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
        nop();
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ex_busy) busy_cnt++;
        end
        chk("mul_busy_cycles", busy_cnt, 32'd32);
`else
        rr("op_c_disabled", 4'hC, 5'd13, 5'd1, 5'd2, 32'h0001_0003, 32'd5, 32'd0);
        @(posedge clk); #1;
        chk("no_busy", {31'b0, ex_busy}, 32'h0);
`endif

        repeat (4) nop();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
